// File: rtl/ring_decoder.sv
// ring_decoder: receiving end of the one-hot ring-counter scan bus.
// Converts each accepted one-hot sample to a binary position. Checks that the
// ring advances one position at a time in the rotation order, declares lock
// after enough correct advances, counts revolutions while locked, and reports
// malformed samples and out-of-order advances as faults.
module ring_decoder #(
  parameter int WIDTH    = 8,  // ring length (number of one-hot positions)
  parameter int IDX_W    = 3,  // clog2(WIDTH)
  parameter int LOCK_CNT = 2,  // consecutive correct advances needed to lock (1..15)
  parameter int REV_W    = 8   // revolution counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] ring_in,
  output logic [IDX_W-1:0] index,
  output logic             valid,
  output logic             locked,
  output logic             wrap,
  output logic [REV_W-1:0] rev_count,
  output logic             err_onehot,
  output logic             err_seq,
  output logic [7:0]       fault_cnt
);

  localparam int MC_W = 4;
  localparam logic [MC_W-1:0]  LOCK_TARGET = MC_W'(LOCK_CNT);
  localparam logic [IDX_W-1:0] LAST_POS    = IDX_W'(WIDTH - 1);
  localparam logic [7:0]       FAULT_MAX   = 8'hFF;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] rest;
    rest = v & (v - WIDTH'(1'b1));
    return (v != {WIDTH{1'b0}}) && (rest == {WIDTH{1'b0}});
  endfunction

  // Binary encoder built purely from OR terms: index bit b is the OR of every
  // ring bit whose position has bit b set. No priority, so the result is only
  // meaningful when the input is known to be one-hot.
  function automatic logic [IDX_W-1:0] onehot_to_bin(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int b = 0; b < IDX_W; b++) begin
      for (int i = 0; i < WIDTH; i++) begin
        r[b] = r[b] | (v[i] & i[b]);
      end
    end
    return r;
  endfunction

  // Next position in rotation order; the top position wraps to zero.
  function automatic logic [IDX_W-1:0] successor(input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] s;
    if (p == LAST_POS) begin
      s = {IDX_W{1'b0}};
    end else begin
      s = p + IDX_W'(1'b1);
    end
    return s;
  endfunction

  state_t           state_q, state_d;
  logic             have_prev_q, have_prev_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             wrap_q, wrap_d;
  logic [REV_W-1:0] rev_count_q, rev_count_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_seq_q, err_seq_d;
  logic [7:0]       fault_cnt_q, fault_cnt_d;

  logic             ring_legal;
  logic [IDX_W-1:0] ring_pos;
  logic [IDX_W-1:0] next_pos;
  logic [MC_W-1:0]  match_inc;
  logic             fault_hit;

  // Decode the incoming sample and the expected next position.
  always_comb begin
    ring_legal = is_onehot(ring_in);
    ring_pos   = onehot_to_bin(ring_in);
    next_pos   = successor(index_q);
    match_inc  = match_cnt_q + MC_W'(1'b1);
  end

  // Next-state and output computation for the SEARCH/TRACK tracker.
  always_comb begin
    state_d      = state_q;
    have_prev_d  = have_prev_q;
    match_cnt_d  = match_cnt_q;
    index_d      = index_q;
    valid_d      = 1'b0;
    wrap_d       = 1'b0;
    rev_count_d  = rev_count_q;
    err_onehot_d = 1'b0;
    err_seq_d    = 1'b0;
    fault_hit    = 1'b0;

    if (sample_en) begin
      if (!ring_legal) begin
        // Malformed vector: keep the last good index, forget history, unlock.
        err_onehot_d = 1'b1;
        fault_hit    = 1'b1;
        have_prev_d  = 1'b0;
        match_cnt_d  = {MC_W{1'b0}};
        state_d      = SEARCH;
      end else if (have_prev_q && (ring_pos == index_q)) begin
        // Same position seen again (slow ring, oversampled): nothing to do.
        state_d = state_q;
      end else begin
        case (state_q)
          SEARCH: begin
            index_d     = ring_pos;
            have_prev_d = 1'b1;
            if (!have_prev_q) begin
              match_cnt_d = {MC_W{1'b0}};
            end else if (ring_pos == next_pos) begin
              match_cnt_d = match_inc;
              if (match_inc >= LOCK_TARGET) begin
                state_d = TRACK;
                valid_d = 1'b1;
              end else begin
                state_d = SEARCH;
              end
            end else begin
              // Out-of-order while unlocked just restarts the lock count.
              match_cnt_d = {MC_W{1'b0}};
            end
          end
          TRACK: begin
            index_d = ring_pos;
            if (ring_pos == next_pos) begin
              valid_d = 1'b1;
              if (index_q == LAST_POS) begin
                wrap_d      = 1'b1;
                rev_count_d = rev_count_q + REV_W'(1'b1);
              end else begin
                wrap_d = 1'b0;
              end
            end else begin
              err_seq_d   = 1'b1;
              fault_hit   = 1'b1;
              state_d     = SEARCH;
              have_prev_d = 1'b1;
              match_cnt_d = {MC_W{1'b0}};
            end
          end
          default: begin
            state_d     = SEARCH;
            have_prev_d = 1'b0;
            match_cnt_d = {MC_W{1'b0}};
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end

    if (fault_hit && (fault_cnt_q != FAULT_MAX)) begin
      fault_cnt_d = fault_cnt_q + 8'd1;
    end else begin
      fault_cnt_d = fault_cnt_q;
    end

    locked_d = (state_d == TRACK);
  end

  // State and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SEARCH;
      have_prev_q  <= 1'b0;
      match_cnt_q  <= {MC_W{1'b0}};
      index_q      <= {IDX_W{1'b0}};
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      wrap_q       <= 1'b0;
      rev_count_q  <= {REV_W{1'b0}};
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      fault_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      have_prev_q  <= have_prev_d;
      match_cnt_q  <= match_cnt_d;
      index_q      <= index_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      wrap_q       <= wrap_d;
      rev_count_q  <= rev_count_d;
      err_onehot_q <= err_onehot_d;
      err_seq_q    <= err_seq_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  assign index      = index_q;
  assign valid      = valid_q;
  assign locked     = locked_q;
  assign wrap       = wrap_q;
  assign rev_count  = rev_count_q;
  assign err_onehot = err_onehot_q;
  assign err_seq    = err_seq_q;
  assign fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder: directed scoreboard bench for ring_decoder.
// Stimulus pushes the hand-derived response for each sample into a queue;
// a monitor pops one entry per clock after the edge and compares.
module tb_ring_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [7:0] ring_in;
  logic [2:0] index;
  logic       valid, locked, wrap, err_onehot, err_seq;
  logic [7:0] rev_count, fault_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      nm;
    logic [2:0] idx;
    logic       v, l, w, eo, es;
    logic [7:0] rev, flt;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] exp_rev = 8'd0;
  logic [7:0] exp_flt = 8'd0;

  ring_decoder dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .ring_in(ring_in),
    .index(index), .valid(valid), .locked(locked), .wrap(wrap),
    .rev_count(rev_count), .err_onehot(err_onehot), .err_seq(err_seq),
    .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // One sample per clock: drive on the falling edge, queue the expectation.
  task automatic smp(input logic en, input logic [7:0] v, input logic [2:0] ei,
                     input logic ev, input logic el, input logic ew,
                     input logic eo, input logic es, input string nm);
    exp_t e;
    @(negedge clk);
    sample_en = en;
    ring_in   = v;
    e.nm = nm; e.idx = ei; e.v = ev; e.l = el; e.w = ew;
    e.eo = eo; e.es = es; e.rev = exp_rev; e.flt = exp_flt;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_index"}, 32'(index), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_wrap"}, 32'(wrap), 32'd0);
    chk({tag, "_rev"}, 32'(rev_count), 32'd0);
    chk({tag, "_eoh"}, 32'(err_onehot), 32'd0);
    chk({tag, "_eseq"}, 32'(err_seq), 32'd0);
    chk({tag, "_fault"}, 32'(fault_cnt), 32'd0);
  endtask

  // Initial lock sequence from a fresh reset: 7 -> 0 -> 1.
  task automatic lock_seq(input string tag);
    smp(1'b1, 8'h80, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_first"});
    smp(1'b1, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_adv1"});
    smp(1'b1, 8'h02, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {tag, "_lock"});
  endtask

  // Monitor: compare the queued response one time unit after each edge.
  initial begin
    exp_t e;
    logic [23:0] got, req;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {index, valid, locked, wrap, err_onehot, err_seq, rev_count, fault_cnt};
        req = {e.idx, e.v, e.l, e.w, e.eo, e.es, e.rev, e.flt};
        checks++;
        if (got !== req) begin
          errors++;
          $display("FAIL %s: got idx=%0d v=%b l=%b w=%b eo=%b es=%b rev=%0d flt=%0d expected idx=%0d v=%b l=%b w=%b eo=%b es=%b rev=%0d flt=%0d",
                   e.nm, index, valid, locked, wrap, err_onehot, err_seq, rev_count, fault_cnt,
                   e.idx, e.v, e.l, e.w, e.eo, e.es, e.rev, e.flt);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    rst = 1'b1; sample_en = 1'b0; ring_in = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    reset_checks("por");
    @(negedge clk);
    rst = 1'b0;

    // Lock from reset.
    lock_seq("s1");

    // Continue to the first wrap.
    for (int p = 2; p < 8; p++) begin
      pat = 8'h01 << p;
      smp(1'b1, pat, 3'(p), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s2_adv");
    end
    exp_rev = 8'd1;
    smp(1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "s2_wrap");

    // 256 more revolutions: counter comes back round to 1.
    for (int r = 0; r < 256; r++) begin
      for (int p = 1; p < 8; p++) begin
        pat = 8'h01 << p;
        smp(1'b1, pat, 3'(p), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s2_rev_adv");
      end
      exp_rev = exp_rev + 8'd1;
      smp(1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "s2_rev_wrap");
    end
    #2 chk("s2_rev_roll", 32'(rev_count), 32'd1);

    // Malformed vectors while locked at 3.
    smp(1'b1, 8'h02, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s3_to1");
    smp(1'b1, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s3_to2");
    smp(1'b1, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s3_to3");
    exp_flt = 8'd1;
    smp(1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "s3_zero");
    exp_flt = 8'd2;
    smp(1'b1, 8'h18, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "s3_multi");

    // Relock at 2, then jump to 5 and relock at 7.
    smp(1'b1, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s4_first");
    smp(1'b1, 8'h02, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s4_adv1");
    smp(1'b1, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s4_lock");
    exp_flt = 8'd3;
    smp(1'b1, 8'h20, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "s4_badseq");
    smp(1'b1, 8'h40, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s4_re1");
    smp(1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s4_relock");

    // Oversampling: each pattern held five clocks, one valid per change.
    for (int p = 0; p < 4; p++) begin
      pat = 8'h01 << p;
      if (p == 0) exp_rev = 8'd2;
      smp(1'b1, pat, 3'(p), 1'b1, 1'b1, (p == 0), 1'b0, 1'b0, "s5_change");
      for (int k = 0; k < 4; k++)
        smp(1'b1, pat, 3'(p), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s5_hold");
    end
    // Garbage with sample_en low is ignored.
    smp(1'b0, 8'hFF, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s5_en_low");
    smp(1'b0, 8'h20, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s5_en_low2");

    // Two more revolutions to rev_count=4, then async reset mid-cycle.
    for (int r = 0; r < 2; r++) begin
      for (int p = ((r == 0) ? 4 : 1); p < 8; p++) begin
        pat = 8'h01 << p;
        smp(1'b1, pat, 3'(p), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s6_adv");
      end
      exp_rev = exp_rev + 8'd1;
      smp(1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "s6_wrap");
    end
    #3;
    sample_en = 1'b0;
    rst = 1'b1;
    #1;
    reset_checks("async");
    @(negedge clk);
    rst = 1'b0;
    exp_rev = 8'd0;
    exp_flt = 8'd0;
    lock_seq("s6");

    // Fault counter saturation.
    for (int n = 0; n < 260; n++) begin
      if (exp_flt != 8'hFF) exp_flt = exp_flt + 8'd1;
      smp(1'b1, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "s7_sat");
    end
    smp(1'b1, 8'h02, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s7_after");

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_decoder.md
Name: ring_decoder

Overview:
Receiving end of the 8-bit one-hot ring-counter scan bus. Samples the rotating one-hot vector and converts it to a binary position index. Checks that the pattern is legal and advances in the correct rotation order, and counts full revolutions. Drives scan-synchronised consumers such as digit/column decode and status LEDs, and flags faults on the ring.

Parameters:
WIDTH, 8, ring length in bits (number of one-hot positions)
IDX_W, 3, index width, equal to clog2(WIDTH)
LOCK_CNT, 2, consecutive correct advances required to declare lock (1..15)
REV_W, 8, revolution counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sample_en  in  1  qualifies ring_in this cycle; may be tied high (oversampling)
ring_in  in  WIDTH  one-hot ring vector
index  out  IDX_W  binary position of the set bit in the last accepted sample
valid  out  1  one-cycle pulse when index advances while locked
locked  out  1  level, decoder tracking the ring
wrap  out  1  one-cycle pulse on advance from WIDTH-1 to 0 while locked
rev_count  out  REV_W  completed revolutions while locked
err_onehot  out  1  one-cycle pulse, sampled vector not exactly one-hot
err_seq  out  1  one-cycle pulse, legal one-hot but wrong successor while locked
fault_cnt  out  8  total errors (err_onehot + err_seq), saturates at 255

Behaviour:
- Reset (async, any time, including mid-operation): index=0, valid=0, locked=0, wrap=0, rev_count=0, err_onehot=0, err_seq=0, fault_cnt=0. State=SEARCH, have_prev=0, match_cnt=0. Release takes effect on the first clk edge after rst deasserts.
- Rotation order: the ring shifts left, bit WIDTH-1 wrapping to bit 0. The correct successor of position p is (p+1) mod WIDTH. Example: 1000_0000 -> 0000_0001 -> 0000_0010.
- Sampling: ring_in is evaluated only when sample_en=1. All outputs are registered and update on the same edge that samples, so there is one clk of latency from the sample cycle. With sample_en=0, pulse outputs are 0 and everything else holds.
- One-hot check: popcount(ring_in) must equal 1. Zero or multiple bits set gives err_onehot=1 and fault_cnt+1. index holds, have_prev is cleared, match_cnt=0, locked drops to 0, state=SEARCH. This applies in either state.
- Repeat sample: a legal one-hot whose position equals the stored position is ignored. No pulses, no state change, no error. This supports oversampling a slow ring.
- SEARCH state:
  - Legal sample with have_prev=0: index=pos, have_prev=1, match_cnt=0.
  - Legal new pos equal to the successor of index: index=pos, match_cnt+1. If match_cnt reaches LOCK_CNT, state=TRACK and locked=1, and valid pulses in that same cycle.
  - Legal new pos not the successor: index=pos, match_cnt=0, no error. Unlocked mismatches are not faults.
  - valid, wrap, err_seq and rev_count are inactive in SEARCH.
- TRACK state:
  - Correct successor: index=pos, valid=1. If the old index was WIDTH-1 and the new index is 0, wrap=1 and rev_count+1, wrapping modulo 2^REV_W.
  - Wrong successor (legal one-hot): err_seq=1, fault_cnt+1, locked=0, state=SEARCH, index=pos, have_prev=1, match_cnt=0.
- fault_cnt saturates at 255 and is cleared only by rst.
- err_onehot and err_seq never assert in the same cycle. wrap implies valid.
- index is a plain binary encoding of the bit position. The multi-bit encoder must be a priority-free OR-reduction, valid only when the one-hot check passes.

Test Plan:
- Reset then ring_in=1000_0000, 0000_0001, 0000_0010, one sample each -> after the 3rd sample: locked=1, valid pulse, index=1. Before that: locked=0, valid=0.
- Locked, continue the sequence to 1000_0000 -> 0000_0001 -> wrap=1, valid=1, index=0, rev_count=1. Run 256 further revolutions -> rev_count wraps to 1.
- Locked at index=3, apply ring_in=0000_0000 -> err_onehot=1, locked=0, index holds at 3, fault_cnt=1. Then 0001_1000 -> err_onehot again, fault_cnt=2.
- Locked at index=2, apply 0010_0000 (index 5) -> err_seq=1, locked=0, index=5. Then 0100_0000, 1000_0000 -> relock on the 2nd advance, index=7.
- sample_en tied high, each pattern held 5 clocks -> exactly one valid pulse per pattern change, no errors.
- Assert rst asynchronously mid-clock while locked with rev_count=4 and fault_cnt=3 -> all outputs read 0 immediately, before the next clk edge. After release, the lock sequence repeats as in the first scenario.
